// File: rtl/jt12_chseq_pkg.sv
// Shared types for the jt12_chseq channel sequencer: write kinds, queue entry
// and the per-channel configuration record.
package jt12_chseq_pkg;

  localparam int FNUM_W  = 11;
  localparam int BLOCK_W = 3;
  localparam int FB_W    = 3;
  localparam int ALG_W   = 3;
  localparam int PMS_W   = 3;
  localparam int AMS_W   = 2;
  localparam int RL_W    = 2;

  localparam logic [RL_W-1:0] RL_RST = 2'b11;

  typedef enum logic [1:0] {
    KIND_LATCH   = 2'd0,
    KIND_FNUM_LO = 2'd1,
    KIND_FBALG   = 2'd2,
    KIND_PMS     = 2'd3
  } wr_kind_e;

  typedef struct packed {
    wr_kind_e   kind;
    logic [2:0] ch;
    logic [7:0] data;
  } wr_entry_t;

  typedef struct packed {
    logic [FNUM_W-1:0]  fnum;
    logic [BLOCK_W-1:0] block;
    logic [FB_W-1:0]    fb;
    logic [ALG_W-1:0]   alg;
    logic [PMS_W-1:0]   pms;
    logic [AMS_W-1:0]   ams;
  } ch_cfg_t;

endpackage

// File: rtl/jt12_chseq_fifo.sv
// Synchronous show-ahead queue for pending register writes; full blocks
// enqueue even when a dequeue happens in the same cycle.
module jt12_chseq_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (wr_en && !full) begin
      mem_d[wr_ptr_q[AW-1:0]] = wr_data;
      wr_ptr_d = wr_ptr_q + (AW+1)'(1);
    end
    if (rd_en && !empty) begin
      rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/jt12_chseq.sv
// Channel/operator slot sequencer with queued per-channel register writes.
// Define JT12_CHSEQ_RL_EN to store a per-channel rl field (else rl_I is tied to 2'b11).
module jt12_chseq
  import jt12_chseq_pkg::*;
#(
  parameter int NUM_CH     = 6,
  parameter int NUM_OP     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [1:0]  wr_kind,
  input  logic [2:0]  wr_ch,
  input  logic [7:0]  wr_data,
  output logic [2:0]  cur_ch,
  output logic [1:0]  cur_op,
  output logic        zero,
  output logic [10:0] fnum_I,
  output logic [2:0]  block_I,
  output logic [2:0]  fb_I,
  output logic [2:0]  alg_I,
  output logic [2:0]  pms_I,
  output logic [1:0]  ams_I,
  output logic [1:0]  rl_I,
  output logic        err_drop
);

  localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);
  localparam logic [1:0] LAST_OP = 2'(NUM_OP - 1);

  logic [2:0] cur_ch_q, cur_ch_d, next_ch;
  logic [1:0] cur_op_q, cur_op_d, next_op;
  logic       zero_q, zero_d;
  logic       err_drop_q, err_drop_d;
  logic [5:0] latch_q, latch_d;
  ch_cfg_t    out_q, out_d;
  // Sized for the full 3-bit channel field; entries >= NUM_CH are never written.
  ch_cfg_t    ch_q [8];
  ch_cfg_t    ch_d [8];
`ifdef JT12_CHSEQ_RL_EN
  logic [RL_W-1:0] rl_q [8];
  logic [RL_W-1:0] rl_d [8];
  logic [RL_W-1:0] rl_out_q, rl_out_d;
`endif

  wr_entry_t                      wr_entry, head;
  logic [$bits(wr_entry_t)-1:0]   head_bits;
  logic                           fifo_full, fifo_empty, deq;
  logic                           head_bad, head_hit;

  assign wr_entry.kind = wr_kind_e'(wr_kind);
  assign wr_entry.ch   = wr_ch;
  assign wr_entry.data = wr_data;
  assign head          = wr_entry_t'(head_bits);
  assign wr_ready      = !fifo_full;

  jt12_chseq_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(wr_entry_t))
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_valid && !fifo_full),
    .wr_data (wr_entry),
    .rd_en   (deq),
    .rd_data (head_bits),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign next_ch  = (cur_ch_q == LAST_CH) ? 3'd0 : cur_ch_q + 3'd1;
  assign next_op  = (cur_ch_q != LAST_CH) ? cur_op_q :
                    (cur_op_q == LAST_OP) ? 2'd0 : cur_op_q + 2'd1;
  assign head_bad = {1'b0, head.ch} >= 4'(NUM_CH);
  assign head_hit = (cur_op_q == 2'd0) && (cur_ch_q == head.ch);

  always_comb begin
    cur_ch_d   = cur_ch_q;
    cur_op_d   = cur_op_q;
    zero_d     = zero_q;
    latch_d    = latch_q;
    ch_d       = ch_q;
    out_d      = out_q;
    err_drop_d = 1'b0;
    deq        = 1'b0;
`ifdef JT12_CHSEQ_RL_EN
    rl_d       = rl_q;
    rl_out_d   = rl_out_q;
`endif
    if (clk_en) begin
      cur_ch_d = next_ch;
      cur_op_d = next_op;
      zero_d   = (next_ch == 3'd0) && (next_op == 2'd0);
      // Outputs load the slot we are moving into; a write applied this edge
      // targets cur_ch, which is never next_ch, so no bypass is needed.
      out_d    = ch_q[next_ch];
`ifdef JT12_CHSEQ_RL_EN
      rl_out_d = rl_q[next_ch];
`endif
      if (!fifo_empty) begin
        if (head_bad) begin
          deq        = 1'b1;
          err_drop_d = 1'b1;
        end else if (head.kind == KIND_LATCH) begin
          latch_d = head.data[5:0];
          deq     = 1'b1;
        end else if (head_hit) begin
          deq = 1'b1;
          case (head.kind)
            KIND_FNUM_LO: {ch_d[head.ch].block, ch_d[head.ch].fnum} = {latch_q, head.data};
            KIND_FBALG: begin
              ch_d[head.ch].fb  = head.data[5:3];
              ch_d[head.ch].alg = head.data[2:0];
            end
            KIND_PMS: begin
              ch_d[head.ch].ams = head.data[5:4];
              ch_d[head.ch].pms = head.data[2:0];
`ifdef JT12_CHSEQ_RL_EN
              rl_d[head.ch]     = head.data[7:6];
`endif
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur_ch_q   <= '0;
      cur_op_q   <= '0;
      zero_q     <= 1'b1;
      err_drop_q <= 1'b0;
      latch_q    <= '0;
      out_q      <= '0;
      ch_q       <= '{default: '0};
`ifdef JT12_CHSEQ_RL_EN
      rl_q       <= '{default: RL_RST};
      rl_out_q   <= RL_RST;
`endif
    end else begin
      cur_ch_q   <= cur_ch_d;
      cur_op_q   <= cur_op_d;
      zero_q     <= zero_d;
      err_drop_q <= err_drop_d;
      latch_q    <= latch_d;
      out_q      <= out_d;
      ch_q       <= ch_d;
`ifdef JT12_CHSEQ_RL_EN
      rl_q       <= rl_d;
      rl_out_q   <= rl_out_d;
`endif
    end
  end

  assign cur_ch   = cur_ch_q;
  assign cur_op   = cur_op_q;
  assign zero     = zero_q;
  assign err_drop = err_drop_q;
  assign fnum_I   = out_q.fnum;
  assign block_I  = out_q.block;
  assign fb_I     = out_q.fb;
  assign alg_I    = out_q.alg;
  assign pms_I    = out_q.pms;
  assign ams_I    = out_q.ams;
`ifdef JT12_CHSEQ_RL_EN
  assign rl_I     = rl_out_q;
`else
  assign rl_I     = RL_RST;
`endif

endmodule

// File: tb/tb_jt12_chseq.sv
// Directed bench for jt12_chseq: slot sequence, pitch write, backpressure,
// invalid channel drop, reset with queued writes and the rl option.
module tb_jt12_chseq;

`ifdef JT12_CHSEQ_RL_EN
  localparam logic [1:0] RL_40 = 2'd1;
  localparam logic [1:0] RL_96 = 2'd2;
`else
  localparam logic [1:0] RL_40 = 2'd3;
  localparam logic [1:0] RL_96 = 2'd3;
`endif

  logic        clk, rst_n, clk_en;
  logic        wr_valid, wr_ready;
  logic [1:0]  wr_kind;
  logic [2:0]  wr_ch;
  logic [7:0]  wr_data;
  logic [2:0]  cur_ch;
  logic [1:0]  cur_op;
  logic        zero, err_drop;
  logic [10:0] fnum_I;
  logic [2:0]  block_I, fb_I, alg_I, pms_I;
  logic [1:0]  ams_I, rl_I;

  logic        t3_valid, t3_ready;
  logic [1:0]  t3_kind;
  logic [2:0]  t3_ch;
  logic [7:0]  t3_data;
  logic [2:0]  t3_cur_ch;
  logic [1:0]  t3_cur_op;
  logic        t3_zero, t3_err_drop;
  logic [10:0] t3_fnum;
  logic [2:0]  t3_block, t3_fb, t3_alg, t3_pms;
  logic [1:0]  t3_ams, t3_rl;

  int n_chk = 0;
  int n_err = 0;
  int m_ch  = 0;
  int m_op  = 0;

  jt12_chseq #(.NUM_CH(6), .NUM_OP(4), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_kind(wr_kind), .wr_ch(wr_ch), .wr_data(wr_data),
    .cur_ch(cur_ch), .cur_op(cur_op), .zero(zero),
    .fnum_I(fnum_I), .block_I(block_I), .fb_I(fb_I), .alg_I(alg_I),
    .pms_I(pms_I), .ams_I(ams_I), .rl_I(rl_I), .err_drop(err_drop)
  );

  jt12_chseq #(.NUM_CH(3), .NUM_OP(4), .FIFO_DEPTH(4)) dut3 (
    .clk(clk), .rst_n(rst_n), .clk_en(clk_en),
    .wr_valid(t3_valid), .wr_ready(t3_ready),
    .wr_kind(t3_kind), .wr_ch(t3_ch), .wr_data(t3_data),
    .cur_ch(t3_cur_ch), .cur_op(t3_cur_op), .zero(t3_zero),
    .fnum_I(t3_fnum), .block_I(t3_block), .fb_I(t3_fb), .alg_I(t3_alg),
    .pms_I(t3_pms), .ams_I(t3_ams), .rl_I(t3_rl), .err_drop(t3_err_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock and the reference slot counter for the 6-channel DUT.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) begin
      m_ch = 0;
      m_op = 0;
    end else if (clk_en) begin
      if (m_ch == 5) begin
        m_ch = 0;
        m_op = (m_op + 1) % 4;
      end else begin
        m_ch++;
      end
    end
    #1;
  endtask

  task automatic wait_ch(input int c);
    int n = 0;
    while (m_ch != c && n < 30) begin
      tick();
      n++;
    end
  endtask

  task automatic put(input logic [1:0] k, input logic [2:0] c, input logic [7:0] d);
    wr_valid = 1'b1;
    wr_kind  = k;
    wr_ch    = c;
    wr_data  = d;
  endtask

  logic [1:0] bp_kind [5] = '{2'd1, 2'd0, 2'd1, 2'd2, 2'd3};
  logic [7:0] bp_data [5] = '{8'h11, 8'h0A, 8'h22, 8'h2B, 8'h96};

  initial begin
    int zeros;
    int pulses;
    int n;
    rst_n = 1'b0; clk_en = 1'b0;
    wr_valid = 1'b0; wr_kind = '0; wr_ch = '0; wr_data = '0;
    t3_valid = 1'b0; t3_kind = '0; t3_ch = '0; t3_data = '0;

    repeat (3) tick();
    check("rst_cur_ch", cur_ch, 0);
    check("rst_cur_op", cur_op, 0);
    check("rst_zero", zero, 1);
    check("rst_wr_ready", wr_ready, 1);
    check("rst_err_drop", err_drop, 0);
    check("rst_fnum", fnum_I, 0);
    check("rst_block", block_I, 0);
    check("rst_fb", fb_I, 0);
    check("rst_alg", alg_I, 0);
    check("rst_pms", pms_I, 0);
    check("rst_ams", ams_I, 0);
    check("rst_rl", rl_I, 3);

    // Slot sequence over two full rotations.
    rst_n = 1'b1; clk_en = 1'b1;
    zeros = 0;
    for (int i = 0; i < 48; i++) begin
      tick();
      check("seq_ch", cur_ch, m_ch);
      check("seq_op", cur_op, m_op);
      check("seq_zero", zero, (m_ch == 0 && m_op == 0));
      if (zero) zeros++;
    end
    check("seq_zero_count", zeros, 2);

    // Pitch: latch 0x2C then fnum_lo ch2 0x55 -> fnum 0x455, block 5.
    put(2'd0, 3'd0, 8'h2C);
    check("pitch_ready", wr_ready, 1);
    tick();
    put(2'd1, 3'd2, 8'h55);
    tick();
    wr_valid = 1'b0;
    repeat (48) tick();
    for (int i = 0; i < 24; i++) begin
      tick();
      check("pitch_fnum", fnum_I, (m_ch == 2) ? 11'h455 : 11'h000);
      check("pitch_block", block_I, (m_ch == 2) ? 3'd5 : 3'd0);
    end

    // Backpressure: fill the queue with clk_en low, then resume.
    clk_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      put(bp_kind[i], 3'd5, bp_data[i]);
      check("bp_ready_fill", wr_ready, 1);
      tick();
    end
    put(bp_kind[4], 3'd5, bp_data[4]);
    check("bp_ready_full", wr_ready, 0);
    n = m_ch;
    tick();
    check("bp_ready_hold", wr_ready, 0);
    check("bp_slot_hold", cur_ch, n);
    clk_en = 1'b1;
    n = 0;
    while (wr_ready !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    check("bp_resume", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    repeat (130) tick();
    check("bp_drained", wr_ready, 1);
    wait_ch(5);
    check("bp_fnum", fnum_I, 11'h222);
    check("bp_block", block_I, 1);
    check("bp_fb", fb_I, 5);
    check("bp_alg", alg_I, 3);
    check("bp_pms", pms_I, 6);
    check("bp_ams", ams_I, 1);
    check("bp_rl", rl_I, RL_96);
    wait_ch(2);
    check("bp_ch2_fnum", fnum_I, 11'h455);
    check("bp_ch2_fb", fb_I, 0);

    // Invalid channel on the 3-channel instance.
    t3_valid = 1'b1; t3_kind = 2'd2; t3_ch = 3'd6; t3_data = 8'h3F;
    check("inv_ready", t3_ready, 1);
    tick();
    t3_valid = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (t3_err_drop) pulses++;
      check("inv_err_drop", t3_err_drop, (i == 0));
      check("inv_fb", t3_fb, 0);
      check("inv_alg", t3_alg, 0);
      check("inv_main_err", err_drop, 0);
    end
    check("inv_pulses", pulses, 1);
    check("inv_empty", t3_ready, 1);

    // Reset with three writes queued.
    clk_en = 1'b0;
    put(2'd2, 3'd1, 8'h3F); tick();
    put(2'd1, 3'd0, 8'hFF); tick();
    put(2'd3, 3'd3, 8'hFF); tick();
    wr_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_cur_ch", cur_ch, 0);
    check("mrst_cur_op", cur_op, 0);
    check("mrst_zero", zero, 1);
    check("mrst_wr_ready", wr_ready, 1);
    check("mrst_fnum", fnum_I, 0);
    check("mrst_block", block_I, 0);
    check("mrst_fb", fb_I, 0);
    check("mrst_alg", alg_I, 0);
    check("mrst_pms", pms_I, 0);
    check("mrst_ams", ams_I, 0);
    check("mrst_rl", rl_I, 3);
    check("mrst_err_drop", err_drop, 0);
    clk_en = 1'b1;
    for (int i = 0; i < 48; i++) begin
      tick();
      check("mrst_cfg", {fnum_I, block_I, fb_I, alg_I, pms_I, ams_I}, 0);
      check("mrst_rl_run", rl_I, 3);
    end

    // rl option: kind3 data 0x40 on ch4.
    put(2'd3, 3'd4, 8'h40);
    tick();
    wr_valid = 1'b0;
    repeat (30) tick();
    wait_ch(4);
    check("cfg_rl", rl_I, RL_40);
    check("cfg_ams", ams_I, 0);
    check("cfg_pms", pms_I, 0);
    wait_ch(3);
    check("cfg_rl_other", rl_I, 3);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
